instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the opcode decoder/control unit. Holds the PC and issues requests to instruction memory over a
//  req/ack handshake. Latches the returned word into an instruction register and presents it (opcode + fields)
//  to decode/execute. Applies next-PC redirect (jump/branch) and sticky HALT once execute reports completion.
// PARAMETERS
//  INSTR_W   16      instruction width; opcode = instr[INSTR_W-1 -: 4]
//  PC_W      8       PC / instruction-address width (word addressed)
//  RESET_PC  8'h00   PC value loaded at reset
//  CNT_W     16      width of retired-instruction counter
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        reset, synchronous, active-low
//  imem_req     out  1        instruction read request, held until imem_ack
//  imem_addr    out  PC_W     read address (= pc while imem_req)
//  imem_ack     in   1        read data valid this cycle
//  imem_rdata   in   INSTR_W  instruction word, sampled when imem_req & imem_ack
//  instr        out  INSTR_W  instruction register
//  opcode       out  4        instr[INSTR_W-1 -: 4], to control unit
//  instr_valid  out  1        instr is live for decode/execute
//  stage_done   in   1        execute finished current instr (sampled only while instr_valid)
//  halt         in   1        control unit HALT for current instr
//  jump         in   1        control unit Jump for current instr
//  branch_taken in   1        Branch & resolved condition for current instr
//  target       in   PC_W     absolute redirect address (jump/branch)
//  pc           out  PC_W     address of current/next fetched instr
//  pc_plus1     out  PC_W     pc + 1 (mod 2^PC_W), for JUMPL link
//  halted       out  1        core stopped
//  retired_cnt  out  CNT_W    count of completed non-HALT instrs, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, retired_cnt=0.
//   Reset has priority over every other input in any state; in-flight ack after reset is ignored.
//  FSM: IDLE -> FETCH (unconditional, 1 cycle).
//   FETCH: imem_req=1, imem_addr=pc; on edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, -> EXEC.
//     No ack: stay, req held, address stable (unbounded wait states).
//   EXEC: instr_valid=1, instr stable; on edge with stage_done=1:
//     halt=1          -> HALTED; pc unchanged; halted<=1; instr_valid<=0; retired_cnt unchanged.
//     else jump=1     -> pc<=target; else branch_taken=1 -> pc<=target; else pc<=pc+1.
//     non-halt: instr_valid<=0, retired_cnt+=1 (saturate at all-ones), -> FETCH.
//     stage_done=0: stay; pc, instr unchanged.
//   HALTED: terminal until reset; imem_req=0, instr_valid=0, all inputs ignored.
//  Priority on completion: halt > jump > branch_taken > sequential. Simultaneous jump & branch_taken -> target.
//  pc arithmetic modulo 2^PC_W: pc=2^PC_W-1 sequential -> 0. pc_plus1 combinational from pc, same wrap.
//  imem_ack outside FETCH ignored; halt/jump/branch_taken/target outside EXEC&stage_done ignored.
//  instr=0 decodes as HALT; consumers must qualify opcode with instr_valid.
//  Throughput: min 2 cycles/instr (1 FETCH with immediate ack + 1 EXEC); each imem wait state adds 1.
//  All outputs registered except opcode, pc_plus1, imem_addr (pure wiring/increment of registers).
// STRUCTURE
//  Shared package cpu_pkg: INSTR_W, PC_W, opcode localparams (OP_HALT=4'b0000, OP_ADD=4'b0001 .. OP_OR=4'b1111),
//   fetch state enum {IDLE, FETCH, EXEC, HALTED}; control unit and this block import it.
//  One sub-module: next_pc_sel (combinational: pc, target, jump, branch_taken -> next_pc, pc_plus1).
//  FSM, instr register, retired counter stay in this module.
// TESTING
//  1 Reset: rst_n=0 2 cycles, release -> pc=8'h00, imem_req=0 cycle1, =1 cycle2, halted=0, retired_cnt=0.
//  2 Sequential: imem returns ADD (16'h1123) with 0 and 3 wait states, stage_done 1 cycle -> pc 0->1->2,
//    instr_valid high exactly in EXEC, retired_cnt=2, imem_addr stable during waits.
//  3 Redirect: at pc=8'h05 jump=1,target=8'h20 -> next imem_addr=8'h20; jump=0,branch_taken=1,target=8'h10
//    -> 8'h10; both high -> target; branch_taken=0 -> pc+1.
//  4 Wrap: RESET_PC=8'hFF, sequential completion -> pc=8'h00; pc_plus1 at 8'hFF = 8'h00.
//  5 Halt: opcode 0000 with halt=1 & stage_done -> halted=1 next cycle, pc held, imem_req=0 forever,
//    later acks/stage_done ignored, retired_cnt unchanged.
//  6 Reset mid-op: rst_n=0 during FETCH wait and during EXEC -> all outputs at reset values next edge,
//    stray imem_ack in IDLE ignored; saturation: preload near-max counter (CNT_W=4) -> holds 4'hF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode map and fetch-stage state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

  // Default datapath widths shared by fetch and control.
  localparam int INSTR_W  = 16;
  localparam int PC_W     = 8;
  localparam int OPCODE_W = 4;

  // Opcode map (instr[INSTR_W-1 -: 4]). An all-zero word decodes as HALT.
  localparam logic [OPCODE_W-1:0] OP_HALT  = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_AND   = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_STORE = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_JUMP  = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_JUMPL = 4'b1010;
  localparam logic [OPCODE_W-1:0] OP_JR    = 4'b1011;
  localparam logic [OPCODE_W-1:0] OP_SLT   = 4'b1100;
  localparam logic [OPCODE_W-1:0] OP_SHL   = 4'b1101;
  localparam logic [OPCODE_W-1:0] OP_SHR   = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_OR    = 4'b1111;

  // Fetch-stage sequencing: one idle cycle after reset, then FETCH/EXEC until HALTED.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  // Decode helper for consumers; only meaningful when qualified with instr_valid.
  function automatic logic is_halt_op(input logic [OPCODE_W-1:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Next-PC selection: redirect to target on jump or taken branch, otherwise pc + 1.
// Latency: combinational.
// Backpressure: none; the caller decides when next_pc is loaded.
module next_pc_sel #(
  parameter int PC_W = cpu_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] target,
  input  logic            jump,
  input  logic            branch_taken,
  output logic [PC_W-1:0] next_pc,
  output logic [PC_W-1:0] pc_plus1
);

  // Sequential successor wraps naturally at 2^PC_W; also used as the JUMPL link value.
  assign pc_plus1 = pc + PC_W'(1);

  // Jump and taken branch share the same absolute target, so either one redirects.
  always_comb begin
    next_pc = pc_plus1;
    if (jump || branch_taken) begin
      next_pc = target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads imem over req/ack, holds the instruction register, applies redirect and sticky halt.
// Latency: one idle cycle after reset, then at least 2 cycles per instruction (FETCH with same-cycle ack + EXEC).
// Backpressure: FETCH holds imem_req/imem_addr until imem_ack; EXEC holds instr/instr_valid until stage_done.
module instr_fetch_unit #(
  parameter int              INSTR_W  = cpu_pkg::INSTR_W,
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic               instr_valid,
  input  logic               stage_done,
  input  logic               halt,
  input  logic               jump,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    target,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus1,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_cnt
);
  import cpu_pkg::*;

  fetch_state_e    state;
  logic [PC_W-1:0] next_pc;

  next_pc_sel #(
    .PC_W (PC_W)
  ) u_next_pc_sel (
    .pc           (pc),
    .target       (target),
    .jump         (jump),
    .branch_taken (branch_taken),
    .next_pc      (next_pc),
    .pc_plus1     (pc_plus1)
  );

  // The request address is the PC itself; it cannot move while a request is outstanding.
  assign imem_addr = pc;
  assign opcode    = instr[INSTR_W-1 -: 4];

  // Fetch sequencer with registered handshake/status outputs; reset beats every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (stage_done) begin
            instr_valid <= 1'b0;
            if (halt) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
              if (retired_cnt != '1) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
              end
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Registered status flags must always agree with the sequencer state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (imem_req == (state == FETCH));
      assert (instr_valid == (state == EXEC));
      assert (halted == (state == HALTED));
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances share stimulus (default config and RESET_PC=FF/CNT_W=4).
// Inputs change and outputs are sampled on the falling clock edge.
// Table vectors, hand-written corner sequences, then randomized traffic against a transaction-level model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stage_done;
  logic        halt;
  logic        jump;
  logic        branch_taken;
  logic [7:0]  target;

  logic        imem_req,    imem_req_b;
  logic [7:0]  imem_addr,   imem_addr_b;
  logic [15:0] instr,       instr_b;
  logic [3:0]  opcode,      opcode_b;
  logic        instr_valid, instr_valid_b;
  logic [7:0]  pc,          pc_b;
  logic [7:0]  pc_plus1,    pc_plus1_b;
  logic        halted,      halted_b;
  logic [15:0] retired_cnt;
  logic [3:0]  retired_cnt_b;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .INSTR_W (16), .PC_W (8), .RESET_PC (8'h00), .CNT_W (16)
  ) u_dut (
    .clk (clk), .rst_n (rst_n),
    .imem_req (imem_req), .imem_addr (imem_addr), .imem_ack (imem_ack), .imem_rdata (imem_rdata),
    .instr (instr), .opcode (opcode), .instr_valid (instr_valid),
    .stage_done (stage_done), .halt (halt), .jump (jump), .branch_taken (branch_taken), .target (target),
    .pc (pc), .pc_plus1 (pc_plus1), .halted (halted), .retired_cnt (retired_cnt)
  );

  instr_fetch_unit #(
    .INSTR_W (16), .PC_W (8), .RESET_PC (8'hFF), .CNT_W (4)
  ) u_wrap (
    .clk (clk), .rst_n (rst_n),
    .imem_req (imem_req_b), .imem_addr (imem_addr_b), .imem_ack (imem_ack), .imem_rdata (imem_rdata),
    .instr (instr_b), .opcode (opcode_b), .instr_valid (instr_valid_b),
    .stage_done (stage_done), .halt (halt), .jump (jump), .branch_taken (branch_taken), .target (target),
    .pc (pc_b), .pc_plus1 (pc_plus1_b), .halted (halted_b), .retired_cnt (retired_cnt_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural PC of each instance, retired counts, halt flag.
  int m_pc, m_pc_b, m_cnt, m_cnt_b;
  bit m_halted;

  typedef struct {
    int          ws;
    logic [15:0] word;
    int          delay;
    logic        h, j, b;
    logic [7:0]  tgt;
    logic [7:0]  exp_pc;
    logic [7:0]  exp_pc_b;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input int ws, input logic [15:0] word, input int delay,
                              input logic h, input logic j, input logic b, input logic [7:0] tgt,
                              input logic [7:0] exp_pc, input logic [7:0] exp_pc_b, input int exp_cnt);
    vec_t v;
    v.ws = ws; v.word = word; v.delay = delay;
    v.h = h; v.j = j; v.b = b; v.tgt = tgt;
    v.exp_pc = exp_pc; v.exp_pc_b = exp_pc_b; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Randomize the control-unit inputs; callers only do this where the DUT must ignore them.
  task automatic rand_ctrl();
    stage_done   = 1'($urandom);
    halt         = 1'($urandom);
    jump         = 1'($urandom);
    branch_taken = 1'($urandom);
    target       = 8'($urandom);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hFFFF;
    stage_done = 1'b1; halt = 1'b1; jump = 1'b1; branch_taken = 1'b1; target = 8'hAA;
    repeat (cycles) @(negedge clk);
    m_pc = 0; m_pc_b = 255; m_cnt = 0; m_cnt_b = 0; m_halted = 1'b0;
    check("rst_pc",       32'(pc),          32'h00);
    check("rst_pc_b",     32'(pc_b),        32'hFF);
    check("rst_pc_plus1", 32'(pc_plus1),    32'h01);
    check("rst_pc_plus1_b_wrap", 32'(pc_plus1_b), 32'h00);
    check("rst_req",      32'(imem_req),    32'h0);
    check("rst_valid",    32'(instr_valid), 32'h0);
    check("rst_instr",    32'(instr),       32'h0);
    check("rst_halted",   32'(halted),      32'h0);
    check("rst_cnt",      32'(retired_cnt), 32'h0);
    check("rst_cnt_b",    32'(retired_cnt_b), 32'h0);
    // Release with a stray ack present during the idle cycle.
    rst_n = 1'b1;
    imem_ack = 1'b1;
    stage_done = 1'b0; halt = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    check("idle_to_fetch_req", 32'(imem_req),    32'h1);
    check("idle_ack_valid",    32'(instr_valid), 32'h0);
    check("idle_ack_instr",    32'(instr),       32'h0);
  endtask

  task automatic fetch_instr(input int ws, input logic [15:0] word);
    int guard = 0;
    while (imem_req !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("fetch_req_seen", 32'(imem_req), 32'h1);
    for (int i = 0; i < ws; i++) begin
      imem_ack = 1'b0; imem_rdata = 16'($urandom);
      rand_ctrl();
      @(negedge clk);
      check("wait_req",    32'(imem_req),    32'h1);
      check("wait_req_b",  32'(imem_req_b),  32'h1);
      check("wait_addr",   32'(imem_addr),   32'(m_pc));
      check("wait_addr_b", 32'(imem_addr_b), 32'(m_pc_b));
      check("wait_valid",  32'(instr_valid), 32'h0);
    end
    check("fetch_addr", 32'(imem_addr), 32'(m_pc));
    imem_ack = 1'b1; imem_rdata = word;
    rand_ctrl();
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 16'($urandom);
    stage_done = 1'b0;
    check("exec_valid",   32'(instr_valid),   32'h1);
    check("exec_valid_b", 32'(instr_valid_b), 32'h1);
    check("exec_instr",   32'(instr),         32'(word));
    check("exec_instr_b", 32'(instr_b),       32'(word));
    check("exec_opcode",  32'(opcode),        32'(word[15:12]));
    check("exec_opcode_b", 32'(opcode_b),     32'(word[15:12]));
    check("exec_req_low", 32'(imem_req),      32'h0);
  endtask

  task automatic exec_instr(input int delay, input logic h, input logic j, input logic b, input logic [7:0] tgt);
    for (int i = 0; i < delay; i++) begin
      rand_ctrl();
      stage_done = 1'b0;
      imem_ack = 1'($urandom);
      @(negedge clk);
      check("exec_hold_valid", 32'(instr_valid), 32'h1);
      check("exec_hold_pc",    32'(pc),          32'(m_pc));
      check("exec_hold_req",   32'(imem_req),    32'h0);
    end
    stage_done = 1'b1; halt = h; jump = j; branch_taken = b; target = tgt;
    imem_ack = 1'($urandom);
    @(negedge clk);
    stage_done = 1'b0; halt = 1'b0; jump = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
    // Completion rule: halt > (jump | branch) > sequential; halt retires nothing.
    if (h) begin
      m_halted = 1'b1;
    end else begin
      if (j || b) begin
        m_pc = int'(tgt); m_pc_b = int'(tgt);
      end else begin
        m_pc = (m_pc + 1) % 256; m_pc_b = (m_pc_b + 1) % 256;
      end
      m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_cnt_b = (m_cnt_b < 15) ? m_cnt_b + 1 : 15;
    end
    check("done_pc",       32'(pc),            32'(m_pc));
    check("done_pc_b",     32'(pc_b),          32'(m_pc_b));
    check("done_pc_plus1", 32'(pc_plus1),      32'((m_pc + 1) % 256));
    check("done_pc_plus1_b", 32'(pc_plus1_b),  32'((m_pc_b + 1) % 256));
    check("done_cnt",      32'(retired_cnt),   32'(m_cnt));
    check("done_cnt_b",    32'(retired_cnt_b), 32'(m_cnt_b));
    check("done_halted",   32'(halted),        32'(m_halted));
    check("done_halted_b", 32'(halted_b),      32'(m_halted));
    check("done_valid",    32'(instr_valid),   32'h0);
    check("done_req",      32'(imem_req),      32'(!m_halted));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int          ws, d;
    logic        rj, rb;
    logic [7:0]  rt;
    logic [15:0] rw;

    //          ws word     dly h     j     b     tgt    pc     pc_b   cnt
    vecs[0] = mk(0, 16'h1123, 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 1);
    vecs[1] = mk(3, 16'h1123, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 8'h01, 2);
    vecs[2] = mk(0, 16'h2456, 2, 1'b0, 1'b0, 1'b0, 8'h33, 8'h03, 8'h02, 3);
    vecs[3] = mk(1, 16'h3001, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 8'h03, 4);
    vecs[4] = mk(0, 16'h9ABC, 0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h05, 8'h05, 5);
    vecs[5] = mk(0, 16'h9000, 1, 1'b0, 1'b1, 1'b0, 8'h20, 8'h20, 8'h20, 6);
    vecs[6] = mk(2, 16'h7000, 0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 8'h10, 7);
    vecs[7] = mk(0, 16'h8000, 0, 1'b0, 1'b1, 1'b1, 8'h40, 8'h40, 8'h40, 8);
    vecs[8] = mk(0, 16'h7000, 1, 1'b0, 1'b0, 1'b0, 8'h77, 8'h41, 8'h41, 9);
    vecs[9] = mk(0, 16'h1123, 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h42, 8'h42, 10);

    apply_reset(2);

    for (int i = 0; i < 10; i++) begin
      fetch_instr(vecs[i].ws, vecs[i].word);
      exec_instr(vecs[i].delay, vecs[i].h, vecs[i].j, vecs[i].b, vecs[i].tgt);
      check($sformatf("vec%0d_pc", i),   32'(pc),            32'(vecs[i].exp_pc));
      check($sformatf("vec%0d_pc_b", i), 32'(pc_b),          32'(vecs[i].exp_pc_b));
      check($sformatf("vec%0d_cnt", i),  32'(retired_cnt),   32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_cnt_b", i), 32'(retired_cnt_b), 32'(vecs[i].exp_cnt));
    end

    // Halt wins over a simultaneous jump and taken branch, then everything is ignored.
    fetch_instr(0, 16'h0000);
    exec_instr(1, 1'b1, 1'b1, 1'b1, 8'h99);
    check("halt_pc_held", 32'(pc), 32'h42);
    for (int i = 0; i < 8; i++) begin
      rand_ctrl();
      imem_ack = 1'b1; imem_rdata = 16'($urandom);
      stage_done = 1'b1;
      @(negedge clk);
      check("halted_req",    32'(imem_req),      32'h0);
      check("halted_valid",  32'(instr_valid),   32'h0);
      check("halted_flag",   32'(halted),        32'h1);
      check("halted_pc",     32'(pc),            32'h42);
      check("halted_cnt",    32'(retired_cnt),   32'd10);
      check("halted_cnt_b",  32'(retired_cnt_b), 32'd10);
    end

    // Reset in the middle of a FETCH wait.
    apply_reset(1);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midfetch_req",  32'(imem_req),  32'h1);
    check("midfetch_addr", 32'(imem_addr), 32'h00);
    apply_reset(1);

    // Reset while an instruction sits in EXEC.
    fetch_instr(0, 16'h1123);
    stage_done = 1'b0;
    @(negedge clk);
    check("midexec_valid", 32'(instr_valid), 32'h1);
    apply_reset(1);

    // Randomized traffic; the narrow counter must saturate.
    for (int n = 0; n < 40; n++) begin
      ws = $urandom_range(0, 3);
      d  = $urandom_range(0, 2);
      rw = 16'($urandom);
      rj = ($urandom_range(0, 3) == 0);
      rb = ($urandom_range(0, 3) == 0);
      rt = 8'($urandom);
      fetch_instr(ws, rw);
      exec_instr(d, 1'b0, rj, rb, rt);
    end
    check("rand_cnt",       32'(retired_cnt),   32'd40);
    check("sat_cnt_b_hold", 32'(retired_cnt_b), 32'hF);

    fetch_instr(1, 16'h0000);
    exec_instr(0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("final_halted",   32'(halted),        32'h1);
    check("final_sat_cnt_b", 32'(retired_cnt_b), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
